// File: rtl/motion_update_core_pkg.sv
// Shared types for the kinematic update engine: datapath width and sequencer states.
package motion_update_core_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [2:0] {
    StIdle,
    StMulAt,
    StMulVt,
    StAddP,
    StMulH,
    StAddF,
    StDone
  } state_t;

endpackage

// File: rtl/adder_16bit.sv
// Leaf cell: combinational 16-bit adder with carry in/out.
module adder_16bit (
  output logic        cout,
  output logic [15:0] s,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

// File: rtl/axis_update_lane.sv
// One axis of the kinematic update: operand registers, shared leaf cells and result registers,
// sequenced by the state broadcast from the top-level FSM.
module axis_update_lane
  import motion_update_core_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  state_t           state_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] t_i,
  output logic [WIDTH-1:0] p_new_o,
  output logic [WIDTH-1:0] v_new_o
);

  logic [WIDTH-1:0] p_q, v_q, a_q, t_q;
  logic [WIDTH-1:0] at_q, vt_q, vn_q, pv_q, h_q, ht_q;
  logic [WIDTH-1:0] mul_a, add_a, add_b, add_s, shr;
  logic [31:0]      mul_p;
  logic             unused_cout;
  logic [15:0]      unused_prod_hi;

  // One multiplier and one adder are time-shared across the sequence.
  always_comb begin
    mul_a = h_q;
    add_a = pv_q;
    add_b = ht_q;
    case (state_i)
      StMulAt: mul_a = a_q;
      StMulVt: begin
        mul_a = v_q;
        add_a = v_q;
        add_b = at_q;
      end
      StAddP: begin
        add_a = p_q;
        add_b = vt_q;
      end
      default: ;
    endcase
  end

  multiplier_16bit u_mul (
    .p (mul_p),
    .a (mul_a),
    .b (t_q)
  );

  adder_16bit u_add (
    .cout (unused_cout),
    .s    (add_s),
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0)
  );

  shifter u_shr (
    .in  (at_q),
    .out (shr)
  );

  assign unused_prod_hi = mul_p[31:16];

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q     <= '0;
      v_q     <= '0;
      a_q     <= '0;
      t_q     <= '0;
      at_q    <= '0;
      vt_q    <= '0;
      vn_q    <= '0;
      pv_q    <= '0;
      h_q     <= '0;
      ht_q    <= '0;
      p_new_o <= '0;
      v_new_o <= '0;
    end else begin
      if (load_i) begin
        p_q <= p_i;
        v_q <= v_i;
        a_q <= a_i;
        t_q <= t_i;
      end
      case (state_i)
        StMulAt: at_q <= mul_p[15:0];
        StMulVt: begin
          vt_q <= mul_p[15:0];
          vn_q <= add_s;
        end
        StAddP: begin
          pv_q <= add_s;
          h_q  <= shr;
        end
        StMulH: ht_q <= mul_p[15:0];
        StAddF: begin
          p_new_o <= add_s;
          v_new_o <= vn_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multiplier_16bit.sv
// Leaf cell: combinational unsigned 16x16 -> 32 multiplier.
module multiplier_16bit (
  output logic [31:0] p,
  input  logic [15:0] a,
  input  logic [15:0] b
);
  assign p = {16'd0, a} * {16'd0, b};
endmodule

// File: rtl/shifter.sv
// Leaf cell: combinational logical shift right by one.
module shifter (
  input  logic [15:0] in,
  output logic [15:0] out
);
  assign out = {1'b0, in[15:1]};
endmodule

// File: rtl/motion_update_core.sv
// 2-D constant-acceleration kinematic update: one shared sequencer driving an x and a y lane.
module motion_update_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_rdy,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] vx,
  input  logic [WIDTH-1:0] vy,
  input  logic [WIDTH-1:0] ax,
  input  logic [WIDTH-1:0] ay,
  input  logic [WIDTH-1:0] t,
  output logic             out_rdy,
  output logic [WIDTH-1:0] xnew,
  output logic [WIDTH-1:0] ynew,
  output logic [WIDTH-1:0] vxnew,
  output logic [WIDTH-1:0] vynew
);
  import motion_update_core_pkg::*;

  state_t state_q;
  logic   load;

  assign load = (state_q == StIdle) && in_rdy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      out_rdy <= 1'b0;
    end else begin
      out_rdy <= 1'b0;
      case (state_q)
        StIdle:  if (in_rdy) state_q <= StMulAt;
        StMulAt: state_q <= StMulVt;
        StMulVt: state_q <= StAddP;
        StAddP:  state_q <= StMulH;
        StMulH:  state_q <= StAddF;
        StAddF: begin
          state_q <= StDone;
          out_rdy <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_update_lane u_lane_x (
    .clock   (clock),
    .reset   (reset),
    .state_i (state_q),
    .load_i  (load),
    .p_i     (x),
    .v_i     (vx),
    .a_i     (ax),
    .t_i     (t),
    .p_new_o (xnew),
    .v_new_o (vxnew)
  );

  axis_update_lane u_lane_y (
    .clock   (clock),
    .reset   (reset),
    .state_i (state_q),
    .load_i  (load),
    .p_i     (y),
    .v_i     (vy),
    .a_i     (ay),
    .t_i     (t),
    .p_new_o (ynew),
    .v_new_o (vynew)
  );

endmodule

// File: tb/tb_motion_update_core.sv
// Scoreboard bench for motion_update_core: stimulus pushes expected results, a negedge monitor
// pops and compares them (values and completion cycle) whenever out_rdy is seen.
module tb_motion_update_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_rdy;
  logic [15:0] x, y, vx, vy, ax, ay, t;
  logic        out_rdy;
  logic [15:0] xnew, ynew, vxnew, vynew;

  typedef struct {
    logic [15:0] xn;
    logic [15:0] vxn;
    logic [15:0] yn;
    logic [15:0] vyn;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  motion_update_core #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .in_rdy  (in_rdy),
    .x       (x),
    .y       (y),
    .vx      (vx),
    .vy      (vy),
    .ax      (ax),
    .ay      (ay),
    .t       (t),
    .out_rdy (out_rdy),
    .xnew    (xnew),
    .ynew    (ynew),
    .vxnew   (vxnew),
    .vynew   (vynew)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference formula, evaluated independently per axis.
  task automatic model(input logic [15:0] p, input logic [15:0] v, input logic [15:0] a,
                       input logic [15:0] tt, output logic [15:0] pn, output logic [15:0] vn);
    logic [31:0] at32, vt32, ht32;
    logic [15:0] at, h;
    at32 = a * tt;
    at   = at32[15:0];
    vn   = v + at;
    h    = at >> 1;
    vt32 = v * tt;
    ht32 = h * tt;
    pn   = p + vt32[15:0] + ht32[15:0];
  endtask

  task automatic scramble();
    x  = 16'($urandom);
    y  = 16'($urandom);
    vx = 16'($urandom);
    vy = 16'($urandom);
    ax = 16'($urandom);
    ay = 16'($urandom);
    t  = 16'($urandom);
  endtask

  // Drive one single-cycle request; the push records the cycle six edges later.
  task automatic issue(input logic [15:0] ix, input logic [15:0] ivx, input logic [15:0] iax,
                       input logic [15:0] iy, input logic [15:0] ivy, input logic [15:0] iay,
                       input logic [15:0] it, input logic [15:0] exn, input logic [15:0] evxn,
                       input logic [15:0] eyn, input logic [15:0] evyn, input bit push);
    exp_t e;
    @(posedge clock);
    #1;
    x = ix; vx = ivx; ax = iax; y = iy; vy = ivy; ay = iay; t = it;
    in_rdy = 1'b1;
    if (push) begin
      e.xn = exn; e.vxn = evxn; e.yn = eyn; e.vyn = evyn; e.due = cyc + 6;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    in_rdy = 1'b0;
    scramble();
  endtask

  always @(negedge clock) begin
    if (!reset && out_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_rdy: got out_rdy=1, expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("xnew", {16'd0, xnew}, {16'd0, mon_e.xn});
        check("vxnew", {16'd0, vxnew}, {16'd0, mon_e.vxn});
        check("ynew", {16'd0, ynew}, {16'd0, mon_e.yn});
        check("vynew", {16'd0, vynew}, {16'd0, mon_e.vyn});
        check("latency_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    exp_t        e;
    logic [15:0] pxn, vxn, pyn, vyn;
    reset = 1'b1;
    in_rdy = 1'b0;
    x = '0; y = '0; vx = '0; vy = '0; ax = '0; ay = '0; t = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_out_rdy", {31'd0, out_rdy}, 32'd0);
    check("reset_outputs", {xnew, vxnew} | {ynew, vynew}, 32'd0);

    // Basic, wrap, product truncation, odd at on both axes.
    issue(16'd10, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd2,
          16'd24, 16'd11, 16'd0, 16'd0, 1'b1);
    repeat (8) @(posedge clock);
    issue(16'd0, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1,
          16'hFFFF, 16'h0000, 16'd0, 16'd0, 1'b1);
    repeat (8) @(posedge clock);
    issue(16'd7, 16'd5, 16'h0100, 16'd7, 16'd5, 16'h0100, 16'h0100,
          16'h0507, 16'd5, 16'h0507, 16'd5, 1'b1);
    repeat (8) @(posedge clock);
    issue(16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd3, 16'd1,
          16'd1, 16'd3, 16'd1, 16'd3, 1'b1);
    repeat (8) @(posedge clock);

    // Idle after completion: outputs hold, no pulse.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_out_rdy", {31'd0, out_rdy}, 32'd0);
      check("hold_values", {xnew, vxnew}, {16'd1, 16'd3});
    end

    // Back-to-back: in_rdy held, inputs change every cycle, one job per 7 cycles.
    @(posedge clock);
    #1;
    for (int i = 0; i < 21; i++) begin
      scramble();
      in_rdy = 1'b1;
      if (i % 7 == 0) begin
        model(x, vx, ax, t, pxn, vxn);
        model(y, vy, ay, t, pyn, vyn);
        e.xn = pxn; e.vxn = vxn; e.yn = pyn; e.vyn = vyn; e.due = cyc + 6;
        sb.push_back(e);
      end
      @(posedge clock);
      #1;
    end
    in_rdy = 1'b0;
    repeat (8) @(posedge clock);

    // Abort mid-job with reset, then a fresh job right after.
    issue(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7,
          16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_out_rdy", {31'd0, out_rdy}, 32'd0);
    check("abort_outputs", {xnew, vxnew} | {ynew, vynew}, 32'd0);
    issue(16'd10, 16'd3, 16'd4, 16'd0, 16'd0, 16'd3, 16'd2,
          16'd24, 16'd11, 16'd6, 16'd6, 1'b1);
    repeat (12) @(posedge clock);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
